// File: rtl/move_button_conditioner.sv
// Move button conditioner: four raw active-low pushbuttons in, one clean
// active-low single-cycle move strobe per press out, with optional auto-repeat.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   btn_up_n     raw up button, active-low, asynchronous to clk
//   btn_down_n   raw down button, active-low, asynchronous to clk
//   btn_left_n   raw left button, active-low, asynchronous to clk
//   btn_right_n  raw right button, active-low, asynchronous to clk
//   move_up      active-low 1-cycle strobe, registered
//   move_down    active-low 1-cycle strobe, registered
//   move_left    active-low 1-cycle strobe, registered
//   move_right   active-low 1-cycle strobe, registered
//   busy         high while the direction FSM is not idle
module move_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_n,
  input  logic btn_down_n,
  input  logic btn_left_n,
  input  logic btn_right_n,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic busy
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_RELEASE
  } state_t;

  // Bit order everywhere: 3=up, 2=down, 1=left, 0=right.
  logic [3:0]    w_btn;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_deb;
  logic [CW-1:0] r_cnt [4];

  state_t        r_state;
  logic [1:0]    r_dir;
  logic [TW-1:0] r_tmr;
  logic [3:0]    r_strobe;
  logic [1:0]    w_pick;

  assign w_btn = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= '1;
      r_s2  <= '1;
      r_deb <= '1;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      // Any sample matching the settled level restarts the count.
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Fixed priority up > down > left > right.
  always_comb begin
    w_pick = 2'd0;
    if (!r_deb[3])      w_pick = 2'd3;
    else if (!r_deb[2]) w_pick = 2'd2;
    else if (!r_deb[1]) w_pick = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_dir    <= 2'd0;
      r_tmr    <= '0;
      r_strobe <= '1;
    end else begin
      r_strobe <= '1;
      unique case (r_state)
        S_IDLE: begin
          if (r_deb != 4'hF) begin
            r_dir    <= w_pick;
            r_strobe <= ~(4'b0001 << w_pick);
            r_tmr    <= '0;
            r_state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Release is tested first so it beats a same-cycle expiry.
          if (r_deb[r_dir]) begin
            r_state <= S_RELEASE;
          end else if (REPEAT_EN != 0 && r_tmr == HLD_LAST) begin
            r_strobe <= ~(4'b0001 << r_dir);
            r_tmr    <= '0;
            r_state  <= S_REPEAT;
          end else if (r_tmr != HLD_LAST) begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_REPEAT: begin
          if (r_deb[r_dir]) begin
            r_state <= S_RELEASE;
          end else if (r_tmr == RPT_LAST) begin
            r_strobe <= ~(4'b0001 << r_dir);
            r_tmr    <= '0;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_RELEASE: begin
          if (&r_deb) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign move_up    = r_strobe[3];
  assign move_down  = r_strobe[2];
  assign move_left  = r_strobe[1];
  assign move_right = r_strobe[0];
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_move_button_conditioner.sv
// Bench for move_button_conditioner: expected strobes (cycle, pattern)
// are queued when buttons are driven and matched when the DUT strobes.
module tb_move_button_conditioner;

  typedef struct {
    int         cyc;
    logic [3:0] pat;
  } exp_t;

  localparam logic [3:0] P_UP    = 4'b0111;
  localparam logic [3:0] P_LEFT  = 4'b1101;
  localparam logic [3:0] P_RIGHT = 4'b1110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic u1 = 1'b1, d1 = 1'b1, l1 = 1'b1, r1 = 1'b1;
  logic u2 = 1'b1, d2 = 1'b1, l2 = 1'b1, r2 = 1'b1;
  logic mu1, md1, ml1, mr1, busy1;
  logic mu2, md2, ml2, mr2, busy2;
  logic [3:0] mv1, mv2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int c0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mv1 = {mu1, md1, ml1, mr1};
  assign mv2 = {mu2, md2, ml2, mr2};

  move_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(5),
    .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up_n(u1), .btn_down_n(d1),
    .btn_left_n(l1), .btn_right_n(r1),
    .move_up(mu1), .move_down(md1),
    .move_left(ml1), .move_right(mr1),
    .busy(busy1)
  );

  move_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(5),
    .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .rst(rst),
    .btn_up_n(u2), .btn_down_n(d2),
    .btn_left_n(l2), .btn_right_n(r2),
    .move_up(mu2), .move_down(md2),
    .move_left(ml2), .move_right(mr2),
    .busy(busy2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input int c, input logic [3:0] p);
    exp_t e;
    e.cyc = c;
    e.pat = p;
    q1.push_back(e);
  endtask

  task automatic push2(input int c, input logic [3:0] p);
    exp_t e;
    e.cyc = c;
    e.pat = p;
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (mv1 !== 4'hF) begin
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("d1_pat", 32'(mv1), 32'(e.pat));
          check("d1_cyc", cyc, e.cyc);
        end else begin
          check("d1_spurious", 32'(mv1), 32'hF);
        end
      end
      if (mv2 !== 4'hF) begin
        if (q2.size() > 0) begin
          e = q2.pop_front();
          check("d2_pat", 32'(mv2), 32'(e.pat));
          check("d2_cyc", cyc, e.cyc);
        end else begin
          check("d2_spurious", 32'(mv2), 32'hF);
        end
      end
    end
  end

  initial begin
    step(3);
    check("rst_moves", 32'(mv1), 32'hF);
    check("rst_busy", 32'(busy1), 0);
    check("rst_moves2", 32'(mv2), 32'hF);
    rst = 1'b0;
    mon_en = 1'b1;
    step(2);

    // 1: single press, strobe after edge DEBOUNCE+3
    c0 = cyc;
    u1 = 1'b0;
    push1(c0 + 7, P_UP);
    step(8);
    u1 = 1'b1;
    step(7);
    check("t1_busy_rel", 32'(busy1), 1);
    step(1);
    check("t1_busy_idle", 32'(busy1), 0);
    step(5);
    check("t1_missing", q1.size(), 0);

    // 2: short glitch is filtered
    d1 = 1'b0;
    step(3);
    d1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("t2_busy", 32'(busy1), 0);
    end

    // 3: hold with auto-repeat; release beats expiry at +47
    c0 = cyc;
    r1 = 1'b0;
    push1(c0 + 7, P_RIGHT);
    push1(c0 + 17, P_RIGHT);
    for (int k = 22; k <= 42; k += 5) push1(c0 + k, P_RIGHT);
    step(40);
    r1 = 1'b1;
    step(7);
    check("t3_busy_rel", 32'(busy1), 1);
    step(1);
    check("t3_busy_idle", 32'(busy1), 0);
    step(5);
    check("t3_missing", q1.size(), 0);

    // 4: priority and lockout until all released
    c0 = cyc;
    u1 = 1'b0;
    l1 = 1'b0;
    push1(c0 + 7, P_UP);
    step(5);
    u1 = 1'b1;
    step(15);
    check("t4_busy_lock", 32'(busy1), 1);
    l1 = 1'b1;
    step(6);
    check("t4_busy_rel", 32'(busy1), 1);
    step(1);
    check("t4_busy_idle", 32'(busy1), 0);
    step(13);
    c0 = cyc;
    l1 = 1'b0;
    push1(c0 + 7, P_LEFT);
    step(5);
    l1 = 1'b1;
    step(12);
    check("t4_missing", q1.size(), 0);
    check("t4_busy_end", 32'(busy1), 0);

    // 5: reset mid-repeat with button held
    c0 = cyc;
    u1 = 1'b0;
    push1(c0 + 7, P_UP);
    push1(c0 + 17, P_UP);
    push1(c0 + 22, P_UP);
    step(24);
    rst = 1'b1;
    step(1);
    check("t5_rst_moves", 32'(mv1), 32'hF);
    check("t5_rst_busy", 32'(busy1), 0);
    rst = 1'b0;
    push1(c0 + 32, P_UP);
    step(10);
    u1 = 1'b1;
    step(20);
    check("t5_missing", q1.size(), 0);
    check("t5_busy_end", 32'(busy1), 0);

    // 6: no auto-repeat, one strobe per press
    c0 = cyc;
    u2 = 1'b0;
    push2(c0 + 7, P_UP);
    step(50);
    check("t6_busy_held", 32'(busy2), 1);
    u2 = 1'b1;
    step(15);
    check("t6_missing", q2.size(), 0);
    check("t6_busy_end", 32'(busy2), 0);
    check("t6_d1_quiet", q1.size(), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
